// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: signal bundle around the regfile write-port arbiter.
//   pipe_*     : in-order pipeline writeback (we/rd/wd)
//   mc_*       : multicycle-unit completion handshake (valid/ready, rd/wd)
//   we3/a3/wd3 : regfile write port driven by the arbiter
//   stall_o    : registered pipeline freeze request
//   q_*        : forwarding lookup into queued multicycle results
// Modports: slave = arbiter side, master = pipeline/regfile environment side.
interface wb_arbiter_if;
    logic        pipe_we_i;
    logic [4:0]  pipe_rd_i;
    logic [31:0] pipe_wd_i;
    logic        mc_valid_i;
    logic [4:0]  mc_rd_i;
    logic [31:0] mc_wd_i;
    logic        mc_ready_o;
    logic        we3_o;
    logic [4:0]  a3_o;
    logic [31:0] wd3_o;
    logic        stall_o;
    logic [4:0]  q_rs_i;
    logic        q_hit_o;
    logic [31:0] q_data_o;

    modport slave (
        input  pipe_we_i, pipe_rd_i, pipe_wd_i,
        input  mc_valid_i, mc_rd_i, mc_wd_i,
        output mc_ready_o,
        output we3_o, a3_o, wd3_o,
        output stall_o,
        input  q_rs_i,
        output q_hit_o, q_data_o
    );

    modport master (
        output pipe_we_i, pipe_rd_i, pipe_wd_i,
        output mc_valid_i, mc_rd_i, mc_wd_i,
        input  mc_ready_o,
        input  we3_o, a3_o, wd3_o,
        input  stall_o,
        output q_rs_i,
        input  q_hit_o, q_data_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: owner of the regfile write port (we3/a3/wd3).
// The pipeline writeback has priority and goes straight to the port; multicycle
// completions are queued in a DEPTH-entry FIFO and drained into idle port
// cycles. An accepted pipe write kills older queued writes to the same rd
// (WAW). A forwarding query returns the youngest valid queued value for q_rs_i.
// If a non-empty FIFO is blocked by pipe writes for STARVE_MAX cycles, stall_o
// is raised for one cycle so the head can drain.
// Ports:
//   clk_i : clock, all state on posedge
//   rst_i : asynchronous active-high reset
//   bus   : wb_arbiter_if.slave (pipe_*, mc_*, we3/a3/wd3, stall_o, q_*)
module wb_arbiter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    wb_arbiter_if.slave   bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [4:0]       ent_rd [DEPTH];
    logic [31:0]      ent_wd [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starve_cnt;
    logic             stall_q;

    logic not_empty;
    logic pipe_acc;
    logic pop;
    logic push;
    logic mc_ready;
    logic blocked;

    always_comb begin
        not_empty = (count != '0);
        // Outputs are gated by rst_i so nothing reaches the port while in reset.
        pipe_acc  = !rst_i && bus.pipe_we_i && (bus.pipe_rd_i != 5'd0) && !stall_q;
        pop       = !rst_i && not_empty && !pipe_acc;
        mc_ready  = !rst_i && (count < CW'(DEPTH));
        push      = bus.mc_valid_i && mc_ready && (bus.mc_rd_i != 5'd0);
        blocked   = not_empty && pipe_acc;
    end

    // Write-port mux. A popped entry that was invalidated consumes the cycle
    // but produces no write.
    always_comb begin
        bus.we3_o = 1'b0;
        bus.a3_o  = '0;
        bus.wd3_o = '0;
        if (pipe_acc) begin
            bus.we3_o = 1'b1;
            bus.a3_o  = bus.pipe_rd_i;
            bus.wd3_o = bus.pipe_wd_i;
        end else if (pop && ent_vld[rd_ptr]) begin
            bus.we3_o = 1'b1;
            bus.a3_o  = ent_rd[rd_ptr];
            bus.wd3_o = ent_wd[rd_ptr];
        end
    end

    assign bus.mc_ready_o = mc_ready;
    assign bus.stall_o    = stall_q;

    // Forwarding lookup: walk occupied slots oldest to newest so the last
    // match (the youngest) wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx          = '0;
        bus.q_hit_o  = 1'b0;
        bus.q_data_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && ent_vld[idx] &&
                (ent_rd[idx] == bus.q_rs_i) && (bus.q_rs_i != 5'd0)) begin
                bus.q_hit_o  = 1'b1;
                bus.q_data_o = ent_wd[idx];
            end
        end
    end

    // Payload storage needs no reset: the valid bits and count gate its use.
    always_ff @(posedge clk_i) begin
        if (push) begin
            ent_rd[wr_ptr] <= bus.mc_rd_i;
            ent_wd[wr_ptr] <= bus.mc_wd_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ent_vld    <= '0;
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else begin
            // WAW kill first; a same-cycle push of the same rd is written
            // afterwards and therefore stays valid.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (pipe_acc && (ent_rd[i] == bus.pipe_rd_i)) begin
                    ent_vld[i] <= 1'b0;
                end
            end
            if (pop) begin
                ent_vld[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            if (push) begin
                ent_vld[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end

            // During the stall cycle pipe_acc is 0, so blocked is 0 and the
            // stall cannot repeat back to back.
            if (blocked) begin
                if (starve_cnt == SW'(STARVE_MAX - 1)) begin
                    stall_q    <= 1'b1;
                    starve_cnt <= '0;
                end else begin
                    stall_q    <= 1'b0;
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                stall_q    <= 1'b0;
                starve_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed-vector bench for wb_arbiter (DEPTH=4, STARVE_MAX=8).
// Inputs change 1 ns after posedge; outputs are checked at negedge.
module tb_wb_arbiter;
    logic clk;
    logic rst;
    int   vecs;
    int   errs;

    wb_arbiter_if bus();

    wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic idle();
        bus.pipe_we_i  = 1'b0;
        bus.pipe_rd_i  = '0;
        bus.pipe_wd_i  = '0;
        bus.mc_valid_i = 1'b0;
        bus.mc_rd_i    = '0;
        bus.mc_wd_i    = '0;
        bus.q_rs_i     = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe(input logic we, input logic [4:0] rd, input logic [31:0] wd);
        bus.pipe_we_i = we;
        bus.pipe_rd_i = rd;
        bus.pipe_wd_i = wd;
    endtask

    task automatic set_mc(input logic v, input logic [4:0] rd, input logic [31:0] wd);
        bus.mc_valid_i = v;
        bus.mc_rd_i    = rd;
        bus.mc_wd_i    = wd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        set_pipe(1'b1, 5'd7, 32'hDEAD);
        @(negedge clk);
        vecs++;
        if ({bus.we3_o, bus.a3_o, bus.wd3_o} !== {1'b0, 5'd0, 32'd0}) begin
            errs++;
            $display("FAIL rst_port: got we=%0b a=%0d wd=%h want 0/0/0", bus.we3_o, bus.a3_o, bus.wd3_o);
        end
        vecs++;
        if ({bus.mc_ready_o, bus.stall_o, bus.q_hit_o} !== 3'b000) begin
            errs++;
            $display("FAIL rst_flags: got rdy/stall/hit=%b want 000", {bus.mc_ready_o, bus.stall_o, bus.q_hit_o});
        end
        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        vecs++;
        if ({bus.mc_ready_o, bus.we3_o, bus.stall_o} !== 3'b100) begin
            errs++;
            $display("FAIL rst_release: got rdy/we/stall=%b want 100", {bus.mc_ready_o, bus.we3_o, bus.stall_o});
        end
        tick();
    endtask

    task automatic test_priority();
        idle();
        set_mc(1'b1, 5'd5, 32'hAAAA_0005);
        @(negedge clk);
        vecs++;
        if (bus.we3_o !== 1'b0) begin
            errs++;
            $display("FAIL prio_no_bypass: got we=%0b want 0", bus.we3_o);
        end
        tick();
        idle();
        set_pipe(1'b1, 5'd7, 32'h1234);
        @(negedge clk);
        vecs++;
        if ({bus.we3_o, bus.a3_o, bus.wd3_o} !== {1'b1, 5'd7, 32'h1234}) begin
            errs++;
            $display("FAIL prio_c1: got we=%0b a=%0d wd=%h want 1/7/1234", bus.we3_o, bus.a3_o, bus.wd3_o);
        end
        tick();
        idle();
        @(negedge clk);
        vecs++;
        if ({bus.we3_o, bus.a3_o, bus.wd3_o} !== {1'b1, 5'd5, 32'hAAAA_0005}) begin
            errs++;
            $display("FAIL prio_c2: got we=%0b a=%0d wd=%h want 1/5/aaaa0005", bus.we3_o, bus.a3_o, bus.wd3_o);
        end
        tick();
        @(negedge clk);
        vecs++;
        if (bus.we3_o !== 1'b0) begin
            errs++;
            $display("FAIL prio_c3: got we=%0b want 0", bus.we3_o);
        end
        tick();
    endtask

    task automatic test_full();
        logic [4:0]  exp_rd [5];
        logic [31:0] exp_wd [5];
        for (int i = 0; i < 5; i++) begin
            exp_rd[i] = 5'(12 + i);
            exp_wd[i] = 32'hC1 + 32'(i);
        end
        idle();
        // Four pushes while the pipe owns the port.
        for (int i = 0; i < 4; i++) begin
            set_pipe(1'b1, 5'd30, 32'(i));
            set_mc(1'b1, exp_rd[i], exp_wd[i]);
            @(negedge clk);
            vecs++;
            if ({bus.mc_ready_o, bus.we3_o, bus.a3_o} !== {1'b1, 1'b1, 5'd30}) begin
                errs++;
                $display("FAIL full_push%0d: got rdy=%0b we=%0b a=%0d want 1/1/30", i, bus.mc_ready_o, bus.we3_o, bus.a3_o);
            end
            tick();
        end
        // Fifth held while full.
        set_mc(1'b1, exp_rd[4], exp_wd[4]);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vecs++;
            if (bus.mc_ready_o !== 1'b0) begin
                errs++;
                $display("FAIL full_hold%0d: got rdy=%0b want 0", i, bus.mc_ready_o);
            end
            tick();
        end
        // First pop: still full this cycle, no bypass.
        set_pipe(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        vecs++;
        if ({bus.mc_ready_o, bus.we3_o, bus.a3_o, bus.wd3_o} !== {1'b0, 1'b1, exp_rd[0], exp_wd[0]}) begin
            errs++;
            $display("FAIL full_pop0: got rdy=%0b we=%0b a=%0d wd=%h want 0/1/%0d/%h",
                     bus.mc_ready_o, bus.we3_o, bus.a3_o, bus.wd3_o, exp_rd[0], exp_wd[0]);
        end
        tick();
        @(negedge clk);
        vecs++;
        if (bus.mc_ready_o !== 1'b1) begin
            errs++;
            $display("FAIL full_ready_after_pop: got rdy=%0b want 1", bus.mc_ready_o);
        end
        vecs++;
        if ({bus.we3_o, bus.a3_o, bus.wd3_o} !== {1'b1, exp_rd[1], exp_wd[1]}) begin
            errs++;
            $display("FAIL full_pop1: got we=%0b a=%0d wd=%h", bus.we3_o, bus.a3_o, bus.wd3_o);
        end
        tick();
        idle();
        for (int i = 2; i < 5; i++) begin
            @(negedge clk);
            vecs++;
            if ({bus.we3_o, bus.a3_o, bus.wd3_o} !== {1'b1, exp_rd[i], exp_wd[i]}) begin
                errs++;
                $display("FAIL full_pop%0d: got we=%0b a=%0d wd=%h want 1/%0d/%h",
                         i, bus.we3_o, bus.a3_o, bus.wd3_o, exp_rd[i], exp_wd[i]);
            end
            tick();
        end
        @(negedge clk);
        vecs++;
        if ({bus.we3_o, bus.mc_ready_o} !== 2'b01) begin
            errs++;
            $display("FAIL full_empty: got we/rdy=%b want 01", {bus.we3_o, bus.mc_ready_o});
        end
        tick();
    endtask

    task automatic test_starvation();
        idle();
        set_pipe(1'b1, 5'd10, 32'h100);
        set_mc(1'b1, 5'd9, 32'h99);
        tick();
        set_mc(1'b0, 5'd0, 32'd0);
        bus.q_rs_i = 5'd9;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            vecs++;
            if ({bus.stall_o, bus.we3_o, bus.a3_o} !== {1'b0, 1'b1, 5'd10}) begin
                errs++;
                $display("FAIL starve_c%0d: got stall=%0b we=%0b a=%0d want 0/1/10", c, bus.stall_o, bus.we3_o, bus.a3_o);
            end
            tick();
        end
        @(negedge clk);
        vecs++;
        if ({bus.stall_o, bus.we3_o, bus.a3_o, bus.wd3_o} !== {1'b1, 1'b1, 5'd9, 32'h99}) begin
            errs++;
            $display("FAIL starve_c9: got stall=%0b we=%0b a=%0d wd=%h want 1/1/9/99",
                     bus.stall_o, bus.we3_o, bus.a3_o, bus.wd3_o);
        end
        vecs++;
        if ({bus.q_hit_o, bus.q_data_o} !== {1'b1, 32'h99}) begin
            errs++;
            $display("FAIL starve_fwd: got hit=%0b data=%h want 1/99", bus.q_hit_o, bus.q_data_o);
        end
        tick();
        @(negedge clk);
        vecs++;
        if ({bus.stall_o, bus.we3_o, bus.a3_o, bus.q_hit_o} !== {1'b0, 1'b1, 5'd10, 1'b0}) begin
            errs++;
            $display("FAIL starve_c10: got stall=%0b we=%0b a=%0d hit=%0b want 0/1/10/0",
                     bus.stall_o, bus.we3_o, bus.a3_o, bus.q_hit_o);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_waw_forward();
        idle();
        bus.q_rs_i = 5'd3;
        set_pipe(1'b1, 5'd20, 32'h20);
        set_mc(1'b1, 5'd3, 32'h33);
        tick();
        set_mc(1'b1, 5'd3, 32'h44);
        @(negedge clk);
        vecs++;
        if ({bus.q_hit_o, bus.q_data_o} !== {1'b1, 32'h33}) begin
            errs++;
            $display("FAIL waw_fwd1: got hit=%0b data=%h want 1/33", bus.q_hit_o, bus.q_data_o);
        end
        tick();
        set_mc(1'b0, 5'd0, 32'd0);
        set_pipe(1'b1, 5'd3, 32'h55);
        @(negedge clk);
        vecs++;
        if ({bus.q_hit_o, bus.q_data_o} !== {1'b1, 32'h44}) begin
            errs++;
            $display("FAIL waw_fwd_young: got hit=%0b data=%h want 1/44", bus.q_hit_o, bus.q_data_o);
        end
        vecs++;
        if ({bus.we3_o, bus.a3_o, bus.wd3_o} !== {1'b1, 5'd3, 32'h55}) begin
            errs++;
            $display("FAIL waw_pipe: got we=%0b a=%0d wd=%h want 1/3/55", bus.we3_o, bus.a3_o, bus.wd3_o);
        end
        bus.q_rs_i = 5'd0;
        #1;
        vecs++;
        if ({bus.q_hit_o, bus.q_data_o} !== {1'b0, 32'd0}) begin
            errs++;
            $display("FAIL fwd_x0: got hit=%0b data=%h want 0/0", bus.q_hit_o, bus.q_data_o);
        end
        tick();
        set_pipe(1'b0, 5'd0, 32'd0);
        bus.q_rs_i = 5'd3;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vecs++;
            if ({bus.we3_o, bus.q_hit_o, bus.q_data_o} !== {1'b0, 1'b0, 32'd0}) begin
                errs++;
                $display("FAIL waw_dead_pop%0d: got we=%0b hit=%0b data=%h want 0/0/0", c, bus.we3_o, bus.q_hit_o, bus.q_data_o);
            end
            tick();
        end
        @(negedge clk);
        vecs++;
        if (bus.mc_ready_o !== 1'b1) begin
            errs++;
            $display("FAIL waw_drained: got rdy=%0b want 1", bus.mc_ready_o);
        end
        // Same-cycle pipe write and push of the same rd: push survives.
        set_pipe(1'b1, 5'd3, 32'h66);
        set_mc(1'b1, 5'd3, 32'h77);
        tick();
        idle();
        bus.q_rs_i = 5'd3;
        @(negedge clk);
        vecs++;
        if ({bus.we3_o, bus.a3_o, bus.wd3_o, bus.q_hit_o, bus.q_data_o} !== {1'b1, 5'd3, 32'h77, 1'b1, 32'h77}) begin
            errs++;
            $display("FAIL waw_same_cycle: got we=%0b a=%0d wd=%h hit=%0b data=%h want 1/3/77/1/77",
                     bus.we3_o, bus.a3_o, bus.wd3_o, bus.q_hit_o, bus.q_data_o);
        end
        tick();
        @(negedge clk);
        vecs++;
        if ({bus.we3_o, bus.q_hit_o} !== 2'b00) begin
            errs++;
            $display("FAIL waw_same_cycle_after: got we/hit=%b want 00", {bus.we3_o, bus.q_hit_o});
        end
        tick();
    endtask

    task automatic test_x0();
        idle();
        set_pipe(1'b1, 5'd0, 32'hBAD0);
        set_mc(1'b1, 5'd0, 32'hBAD1);
        @(negedge clk);
        vecs++;
        if (bus.we3_o !== 1'b0) begin
            errs++;
            $display("FAIL x0_both: got we=%0b want 0", bus.we3_o);
        end
        tick();
        // Four x0 pushes while the pipe holds the port would fill the FIFO if kept.
        set_pipe(1'b1, 5'd11, 32'h11);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        @(negedge clk);
        vecs++;
        if ({bus.mc_ready_o, bus.we3_o, bus.a3_o} !== {1'b1, 1'b1, 5'd11}) begin
            errs++;
            $display("FAIL x0_not_queued: got rdy=%0b we=%0b a=%0d want 1/1/11", bus.mc_ready_o, bus.we3_o, bus.a3_o);
        end
        tick();
        idle();
        @(negedge clk);
        vecs++;
        if (bus.we3_o !== 1'b0) begin
            errs++;
            $display("FAIL x0_no_write: got we=%0b want 0", bus.we3_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        for (int i = 0; i < 3; i++) begin
            set_pipe(1'b1, 5'd1, 32'h1);
            set_mc(1'b1, 5'(2 + i), 32'hE0 + 32'(i));
            tick();
        end
        set_mc(1'b0, 5'd0, 32'd0);
        bus.q_rs_i = 5'd3;
        #2;
        vecs++;
        if ({bus.q_hit_o, bus.q_data_o, bus.mc_ready_o} !== {1'b1, 32'hE1, 1'b1}) begin
            errs++;
            $display("FAIL rstmid_pre: got hit=%0b data=%h rdy=%0b want 1/e1/1", bus.q_hit_o, bus.q_data_o, bus.mc_ready_o);
        end
        rst = 1'b1;
        #1;
        vecs++;
        if ({bus.we3_o, bus.a3_o, bus.wd3_o, bus.mc_ready_o} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
            errs++;
            $display("FAIL rstmid_now: got we=%0b a=%0d wd=%h rdy=%0b want 0/0/0/0",
                     bus.we3_o, bus.a3_o, bus.wd3_o, bus.mc_ready_o);
        end
        tick();
        rst = 1'b0;
        idle();
        bus.q_rs_i = 5'd3;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vecs++;
            if ({bus.we3_o, bus.q_hit_o, bus.stall_o, bus.mc_ready_o} !== 4'b0001) begin
                errs++;
                $display("FAIL rstmid_after%0d: got we/hit/stall/rdy=%b want 0001", c,
                         {bus.we3_o, bus.q_hit_o, bus.stall_o, bus.mc_ready_o});
            end
            tick();
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst  = 1'b1;
        idle();
        #1;
        test_reset();
        test_priority();
        test_full();
        test_starvation();
        test_waw_forward();
        test_x0();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-side owner of the register file's single write port (we3/a3/wd3), sitting between the MEM/WB pipeline register and the regfile.
- Merges two writeback sources:
  - the in-order pipeline result, which is zero-latency and has priority;
  - multicycle-unit (mul/div) completions, which are buffered in a small FIFO and drained into idle write-port cycles.
- Provides a forwarding lookup into queued results.
- Raises a pipeline stall when the FIFO has been starved too long.

Parameters:
- DEPTH, 4, FIFO entries for multicycle results; power of two, ≥2.
- STARVE_MAX, 8, consecutive blocked-drain cycles before stall_o is forced; ≥1.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  asynchronous active-high reset.
- pipe_we_i  in  1  pipeline writeback valid.
- pipe_rd_i  in  5  pipeline destination register.
- pipe_wd_i  in  32  pipeline writeback data.
- mc_valid_i  in  1  multicycle result valid.
- mc_rd_i  in  5  multicycle destination register.
- mc_wd_i  in  32  multicycle result data.
- mc_ready_o  out  1  FIFO can accept; transfer happens when mc_valid_i & mc_ready_o.
- we3_o  out  1  regfile write enable.
- a3_o  out  5  regfile write address.
- wd3_o  out  32  regfile write data.
- stall_o  out  1  registered; freezes IF..WB for this cycle.
- q_rs_i  in  5  forwarding query register.
- q_hit_o  out  1  query matched a valid queued entry.
- q_data_o  out  32  data of youngest matching entry; 0 when no hit.

Behaviour:
- Reset (async, rst_i=1):
  - FIFO pointers, count and valid bits cleared.
  - starve counter = 0; stall_o = 0.
  - While in reset: we3_o = 0, a3_o = 0, wd3_o = 0, mc_ready_o = 0.
  - Reset mid-operation discards all queued results.
- Pipe write accepted: pipe_we_i=1 & pipe_rd_i≠0 & stall_o=0. Writes to x0 from either source are dropped and never drive we3_o.
- Write-port mux (combinational, same cycle):
  - Pipe write accepted → we3_o=1, a3_o=pipe_rd_i, wd3_o=pipe_wd_i.
  - Otherwise, if the FIFO head is valid → head drives the port and is popped at posedge.
  - Otherwise → we3_o=0, a3_o=0, wd3_o=0.
- During stall_o=1:
  - pipe_we_i is ignored; the pipeline re-presents the same writeback next cycle.
  - The head drains if non-empty.
- Enqueue:
  - mc_ready_o = (count < DEPTH).
  - Push at posedge when mc_valid_i & mc_ready_o & mc_rd_i≠0.
  - Push and pop in the same cycle are allowed; count stays unchanged.
  - When full, mc_ready_o=0 even if a pop occurs that cycle; there is no full bypass.
  - Minimum latency from mc handshake to we3_o is 1 cycle; there is no same-cycle bypass to the port.
- Invalidation (WAW):
  - An accepted pipe write clears the valid bit of every queued entry with rd == pipe_rd_i; the pipe result is younger.
  - Invalid entries still occupy slots. When popped, they produce we3_o=0 in that cycle, and the port is free for nothing else that cycle.
  - An mc push in the same cycle with the same rd is not invalidated.
- Forwarding query (combinational):
  - Searches valid entries for rd == q_rs_i, newest first.
  - q_rs_i=0 → no hit.
  - The incoming mc_* and pipe_* of the current cycle are not included.
- Starvation:
  - starve_cnt increments each cycle the FIFO is non-empty and a pipe write takes the port.
  - It clears on any pop or when the FIFO is empty.
  - When starve_cnt reaches STARVE_MAX-1 while blocked, stall_o is set for exactly the next cycle and starve_cnt clears.
  - stall_o is never asserted two consecutive cycles from one starvation event.
- Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.

Test Plan:
- Reset sequence: assert rst_i mid-cycle with 3 entries queued → we3_o=0 immediately. After release: mc_ready_o=1, q_hit_o=0, stall_o=0, no stale write ever appears.
- Priority: push mc (rd=5, 0xAAAA_0005) at cycle 0; pipe write (rd=7, 0x1234) at cycle 1; pipe idle at cycle 2.
  - Cycle 1: we3_o=1, a3_o=7, wd3_o=0x1234.
  - Cycle 2: we3_o=1, a3_o=5, wd3_o=0xAAAA_0005.
- Full: push 4 mc results with pipe writing every cycle → mc_ready_o=0 after the 4th push. A 5th mc_valid_i is held and is not accepted until the cycle after the first pop.
- Starvation (STARVE_MAX=8): 1 queued entry and pipe_we_i=1 continuously → stall_o=1 on the 9th cycle. That cycle the head is written; the pipe write appears the following cycle.
- WAW / forwarding:
  - Queue rd=3 (0x33) then rd=3 (0x44) → query q_rs_i=3 returns hit with data 0x44.
  - Then pipe write rd=3 → query misses next cycle, and both pops produce we3_o=0.
- x0: mc_rd_i=0 and pipe_rd_i=0 → nothing queued, count unchanged, we3_o never asserted.
